// File: rtl/memory_interface_pkg.sv
// mem_if_pkg: shared constants for the memory interface slice.
//   DATA_W_DEF / ADDR_W_DEF / TIMEOUT_DEF : parameter defaults
//   ST_*                                  : FSM state encoding
package mem_if_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/memory_interface_if.sv
// memory_interface_if: request/acknowledge bus between the MAR/MDR block
// and the memory.
//   mem_addr, mem_wdata, mem_req, mem_we : driven by the master
//   mem_rdata, mem_ack                   : driven by the memory (slave)
interface memory_interface_if
  import mem_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/memory_interface_timeout_counter.sv
// mem_timeout_counter: counts cycles spent waiting for mem_ack.
//   clock   : clock
//   clear   : async reset, active-low
//   start   : restart the count at 0 (request launch)
//   run     : a wait state is active; count advances each cycle
//   expired : run is high and the count has reached TIMEOUT-1
module mem_timeout_counter
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else if (start || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_interface.sv
// memory_interface: MAR/MDR register pair with a request/ack memory port.
//   clock, clear       : clock and async active-low reset
//   BusMuxOut          : datapath bus value
//   MARin, MDRin       : MAR / MDR load strobes
//   Read, Write        : start a read (with MDRin) / start a write
//   MDR_q              : MDR contents back to the bus mux
//   busy, done, err    : stall, one-cycle completion pulse, sticky error
//   mem                : memory bus (master side)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no transaction; accepts loads and new requests
// RD_WAIT  | read outstanding; MDR takes mem_rdata on ack
// WR_WAIT  | write of MDR outstanding
module memory_interface
  import mem_if_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [DATA_W-1:0]   BusMuxOut,
  input  logic                MARin,
  input  logic                MDRin,
  input  logic                Read,
  input  logic                Write,
  output logic [DATA_W-1:0]   MDR_q,
  output logic                busy,
  output logic                done,
  output logic                err,
  memory_interface_if.master  mem
);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] mdr;
  logic              req_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic              expired;

  logic idle;
  logic rd_start;
  logic wr_start;
  logic conflict;
  logic busy_cmd;
  logic [ADDR_W-1:0] next_mar;

  assign idle     = (state == ST_IDLE);
  assign rd_start = idle && MDRin && Read && !Write;
  assign wr_start = idle && Write && !Read;
  assign conflict = idle && Read && Write;
  assign busy_cmd = !idle && (MDRin || Read || Write);
  assign next_mar = MARin ? BusMuxOut[ADDR_W-1:0] : mar;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .clear   (clear),
    .start   (rd_start || wr_start),
    .run     (!idle),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      mar      <= '0;
      req_addr <= '0;
      mdr      <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mar    <= next_mar;

      if (conflict || busy_cmd) begin
        err_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // MDR load also covers MDRin+Write, so the write carries the new bus value.
          if (MDRin && !Read) begin
            mdr <= BusMuxOut;
          end
          if (rd_start) begin
            state    <= ST_RD_WAIT;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            req_addr <= next_mar;
          end else if (wr_start) begin
            state    <= ST_WR_WAIT;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            req_addr <= next_mar;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          // Ack wins over timeout in the last allowed cycle.
          if (mem.mem_ack) begin
            if (state == ST_RD_WAIT) begin
              mdr <= mem.mem_rdata;
            end
            state  <= ST_IDLE;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b1;
          end else if (expired) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

  // MAR may be reloaded while busy; the bus keeps the address captured at launch.
  assign mem.mem_addr  = req_q ? req_addr : mar;
  assign mem.mem_wdata = mdr;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;

  assign MDR_q = mdr;
  assign busy  = req_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_memory_interface.sv
// tb_memory_interface: directed scenarios plus randomized traffic checked
// against a transaction-level model of the MAR/MDR memory port.
module tb_memory_interface;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] BusMuxOut = '0;
  logic              MARin = 1'b0;
  logic              MDRin = 1'b0;
  logic              Read = 1'b0;
  logic              Write = 1'b0;
  logic [DATA_W-1:0] MDR_q;
  logic              busy;
  logic              done;
  logic              err;

  memory_interface_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  memory_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .clear     (clear),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .MDR_q     (MDR_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem       (mem_bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  // transaction-level model
  logic [ADDR_W-1:0] m_mar;
  logic [DATA_W-1:0] m_mdr;
  logic              m_err;
  logic              m_busy;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  int                m_wait;
  logic              m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mar = '0; m_mdr = '0; m_err = 1'b0; m_busy = 1'b0;
    m_wr = 1'b0; m_addr = '0; m_wait = 0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (m_busy) begin
      if (MDRin || Read || Write) m_err = 1'b1;
      if (mem_bus.mem_ack) begin
        if (!m_wr) m_mdr = mem_bus.mem_rdata;
        m_busy = 1'b0;
        nd = 1'b1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_busy = 1'b0;
        m_err = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      if (Read && Write) begin
        m_err = 1'b1;
      end else if ((MDRin && Read) || Write) begin
        m_busy = 1'b1;
        m_wr   = Write;
        m_wait = 0;
        m_addr = MARin ? BusMuxOut[ADDR_W-1:0] : m_mar;
      end
      if (MDRin && !Read) m_mdr = BusMuxOut;
    end
    if (MARin) m_mar = BusMuxOut[ADDR_W-1:0];
    m_done = nd;
  endtask

  task automatic compare_all();
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = m_busy ? m_addr : m_mar;
    check_val("mdr_q",     MDR_q,                    m_mdr);
    check_val("mem_addr",  32'(mem_bus.mem_addr),    32'(exp_addr));
    check_val("mem_wdata", mem_bus.mem_wdata,        m_mdr);
    check_val("mem_req",   32'(mem_bus.mem_req),     32'(m_busy));
    check_val("mem_we",    32'(mem_bus.mem_we),      32'(m_busy && m_wr));
    check_val("busy",      32'(busy),                32'(m_busy));
    check_val("done",      32'(done),                32'(m_done));
    check_val("err",       32'(err),                 32'(m_err));
    if (busy) busy_cycles++;
    if (done) done_pulses++;
  endtask

  task automatic drive(input logic mar_i, input logic mdr_i, input logic rd_i,
                       input logic wr_i, input logic [31:0] bus_i,
                       input logic ack_i, input logic [31:0] rdata_i);
    @(negedge clock);
    MARin = mar_i; MDRin = mdr_i; Read = rd_i; Write = wr_i; BusMuxOut = bus_i;
    mem_bus.mem_ack = ack_i; mem_bus.mem_rdata = rdata_i;
    @(posedge clock);
    model_edge();
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    clear = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; BusMuxOut = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    model_reset();
    #1 compare_all();
    @(negedge clock);
    clear = 1'b1;
  endtask

  initial begin
    int r_lat;
    int op;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    model_reset();
    #3 compare_all();
    @(negedge clock);
    clear = 1'b1;

    // read of 0x055, ack in third request cycle
    busy_cycles = 0; done_pulses = 0;
    drive(1, 0, 0, 0, 32'h0000_0055, 0, 0);
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    check_val("s1_addr", 32'(mem_bus.mem_addr), 32'h055);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h1234_5678);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_val("s1_mdr", MDR_q, 32'h1234_5678);
    check_val("s1_busy_cycles", 32'(busy_cycles), 32'd3);
    check_val("s1_done_pulses", 32'(done_pulses), 32'd1);

    // MDRin+Write same cycle at MAR 0x1FF
    drive(1, 0, 0, 0, 32'h0000_01FF, 0, 0);
    drive(0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
    check_val("s2_we", 32'(mem_bus.mem_we), 32'd1);
    check_val("s2_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
    check_val("s2_addr", 32'(mem_bus.mem_addr), 32'h1FF);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_val("s2_addr_hold", 32'(mem_bus.mem_addr), 32'h1FF);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h5555_AAAA);
    check_val("s2_done", 32'(done), 32'd1);
    check_val("s2_mdr_kept", MDR_q, 32'hDEAD_BEEF);

    // read with no ack -> timeout
    busy_cycles = 0; done_pulses = 0;
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (!busy) break;
      drive(0, 0, 0, 0, 32'h0, 0, 0);
    end
    check_val("s3_busy_cycles", 32'(busy_cycles), 32'(TIMEOUT));
    check_val("s3_req", 32'(mem_bus.mem_req), 32'd0);
    check_val("s3_err", 32'(err), 32'd1);
    check_val("s3_mdr", MDR_q, 32'hDEAD_BEEF);
    check_val("s3_done_pulses", 32'(done_pulses), 32'd0);

    // Read+Write together in IDLE
    do_reset();
    drive(0, 1, 1, 1, 32'h0BAD_0BAD, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_val("s4_req", 32'(mem_bus.mem_req), 32'd0);
    check_val("s4_err", 32'(err), 32'd1);

    // reset during RD_WAIT, late ack afterwards
    do_reset();
    done_pulses = 0;
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    check_val("s5_mdr", MDR_q, 32'h0);
    check_val("s5_busy", 32'(busy), 32'd0);
    check_val("s5_done_pulses", 32'(done_pulses), 32'd0);

    // MDRin+Read while busy
    do_reset();
    drive(1, 0, 0, 0, 32'h0000_0123, 0, 0);
    drive(0, 1, 1, 0, 32'h0, 0, 0);
    drive(1, 1, 1, 0, 32'h0000_0077, 0, 0);
    check_val("s6_err", 32'(err), 32'd1);
    check_val("s6_busy", 32'(busy), 32'd1);
    check_val("s6_addr_hold", 32'(mem_bus.mem_addr), 32'h123);
    drive(0, 0, 0, 0, 32'h0, 1, 32'hA5A5_0F0F);
    check_val("s6_done", 32'(done), 32'd1);
    check_val("s6_mdr", MDR_q, 32'hA5A5_0F0F);
    check_val("s6_mar", 32'(mem_bus.mem_addr), 32'h077);

    // randomized traffic
    r_lat = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic mr, md, rd, wr, ak;
      logic [31:0] bus, rdat;
      if (cyc % 250 == 0) do_reset();
      mr = 0; md = 0; rd = 0; wr = 0;
      bus = $urandom; rdat = $urandom;
      if (m_busy) begin
        mr = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) begin
          md = $urandom_range(0, 1) == 1; rd = $urandom_range(0, 1) == 1; wr = 1'b1;
        end
        ak = (m_wait == r_lat);
      end else begin
        op = $urandom_range(0, 19);
        if (op < 6) begin
          md = 1; rd = 1; r_lat = $urandom_range(0, 18);
        end else if (op < 10) begin
          wr = 1; md = $urandom_range(0, 1) == 1; r_lat = $urandom_range(0, 18);
        end else if (op == 10) begin
          rd = 1; wr = 1;
        end else if (op < 14) begin
          md = 1; mr = $urandom_range(0, 1) == 1;
        end else if (op < 17) begin
          mr = 1;
        end else if (op == 17) begin
          rd = 1;
        end
        ak = ($urandom_range(0, 5) == 0);
      end
      drive(mr, md, rd, wr, bus, ak, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter DATA_W, default 32, shall set the data path width.
REQ-002 Parameter ADDR_W, default 9, shall set the word-address width (512 words).
REQ-003 Parameter TIMEOUT, default 16, shall set the maximum cycles to wait for mem_ack.
REQ-004 The block shall have one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  shall be the sole clock; all state updates on its rising edge.
REQ-006 clear  in  1  shall be the asynchronous reset, active-low.
REQ-007 BusMuxOut  in  DATA_W  shall be the datapath bus value.
REQ-008 MARin  in  1  shall be the MAR load strobe.
REQ-009 MDRin  in  1  shall be the MDR load strobe.
REQ-010 Read  in  1  shall select the memory source for MDRin and start a read.
REQ-011 Write  in  1  shall start a memory write of MDR to MAR.
REQ-012 mem_rdata  in  DATA_W  shall be the memory read data, valid when mem_ack=1.
REQ-013 mem_ack  in  1  shall be the memory completion handshake.
REQ-014 MDR_q  out  DATA_W  shall be the MDR contents, driven to the bus mux.
REQ-015 mem_addr  out  ADDR_W  shall be the MAR contents.
REQ-016 mem_wdata  out  DATA_W  shall be the write data (MDR contents).
REQ-017 mem_req  out  1  shall be the memory request, held until acknowledged or timed out.
REQ-018 mem_we  out  1  shall be 1 for a write request and 0 for a read request.
REQ-019 busy  out  1  shall be high while a transaction is outstanding (stall to sequencer).
REQ-020 done  out  1  shall be a one-cycle pulse on transaction completion.
REQ-021 err  out  1  shall be a sticky error flag, cleared only by reset.

Function
REQ-022 FSM states IDLE, RD_WAIT, WR_WAIT shall be the only states.
REQ-023 MARin=1 shall load MAR <= BusMuxOut[ADDR_W-1:0] at the edge, in any state.
REQ-024 In IDLE, MDRin=1 with Read=0 shall load MDR <= BusMuxOut.
REQ-025 In IDLE, MDRin=1 with Read=1 shall enter RD_WAIT with mem_req=1 and mem_we=0 from the next cycle.
REQ-026 In IDLE, Write=1 shall enter WR_WAIT with mem_req=1 and mem_we=1; if MDRin=1 and Read=0 in the same cycle, the written data shall be the newly loaded BusMuxOut.
REQ-027 In RD_WAIT, when mem_ack=1 at an edge, the FSM shall set MDR <= mem_rdata, return to IDLE, and pulse done for the following cycle.
REQ-028 In WR_WAIT, when mem_ack=1 at an edge, the FSM shall return to IDLE and pulse done.
REQ-029 Minimum latency from request edge to done shall be 1 cycle (mem_ack high in the first request cycle).
REQ-030 A cycle counter shall start at 0 on entering a wait state; if it reaches TIMEOUT-1 without mem_ack, the FSM shall return to IDLE, leave MDR unchanged, set err, and not pulse done.
REQ-031 busy shall equal mem_req.
REQ-032 MDRin, Read or Write asserted while busy shall be ignored and shall set err; MARin while busy shall still load MAR, and mem_addr shall stay at the value latched at request start.
REQ-033 Read=1 and Write=1 in the same IDLE cycle shall start no transaction and shall set err.
REQ-034 mem_ack=1 in IDLE shall be ignored.

Reset
REQ-035 clear=0 shall force immediately: state IDLE, MAR=0, MDR=0, counter=0, mem_req=0, mem_we=0, busy=0, done=0, err=0.
REQ-036 Reset mid-transaction shall abandon it with no write-back, and a late mem_ack after release shall be ignored.

Structure
REQ-037 Package mem_if_pkg shall hold the state encoding, the DATA_W/ADDR_W defaults, and the TIMEOUT default.
REQ-038 The timeout counter shall be one sub-module, mem_timeout_counter (start, clear, expired).

Verification
REQ-039 Scenario: MARin with bus 0x0000_0055, then MDRin+Read, mem_ack after 3 cycles with rdata 0x1234_5678 -> mem_addr=0x055, MDR_q=0x1234_5678, one done pulse, busy high for 3 cycles.
REQ-040 Scenario: MDRin+Write same cycle with bus 0xDEAD_BEEF, MAR=0x1FF -> mem_we=1, mem_wdata=0xDEAD_BEEF, mem_addr=0x1FF until ack.
REQ-041 Scenario: read with no mem_ack -> after 16 cycles mem_req=0, err=1, MDR unchanged, no done.
REQ-042 Scenario: Read+Write together in IDLE -> mem_req stays 0, err=1.
REQ-043 Scenario: clear low during RD_WAIT, then ack with 0xFFFF_FFFF -> MDR_q=0, state IDLE, no done.
REQ-044 Scenario: MDRin+Read while busy -> ignored, err=1, the outstanding transaction completes normally.
